// File: rtl/ysyx_24080006_pkg.sv
// rtl/ysyx_24080006_pkg.sv - shared types and constants for the ysyx_24080006 core
package ysyx_24080006_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } ifu_state_e;

    localparam logic [31:0] RESET_PC      = 32'h3000_0000;
    localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;
    localparam logic [31:0] NOP_INST      = 32'h0000_0013;

    // Instruction addresses are word aligned; low two bits of any target are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ysyx_24080006_ifu_if.sv
// rtl/ysyx_24080006_ifu_if.sv - fetch unit bundle: redirect, AXI4-Lite read channels, decode handoff
interface ysyx_24080006_ifu_if;

    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        arvalid;
    logic [31:0] araddr;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rready;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_fault;

    modport master (
        input  redirect_valid, redirect_pc,
        input  arready, rvalid, rdata, rresp,
        input  out_ready,
        output arvalid, araddr, rready,
        output out_valid, out_inst, out_pc, out_fault
    );

    modport slave (
        output redirect_valid, redirect_pc,
        output arready, rvalid, rdata, rresp,
        output out_ready,
        input  arvalid, araddr, rready,
        input  out_valid, out_inst, out_pc, out_fault
    );

endinterface

// File: rtl/ysyx_24080006_ifu.sv
// rtl/ysyx_24080006_ifu.sv - instruction fetch unit: PC, single-outstanding read, decode handoff
module ysyx_24080006_ifu #(
    parameter logic [31:0] RESET_PC = ysyx_24080006_pkg::RESET_PC,
    parameter logic [31:0] PC_INCR  = 32'd4
) (
    input  logic                  clock,
    input  logic                  rst_n,
    ysyx_24080006_ifu_if.master   bus
);

    import ysyx_24080006_pkg::*;

    ifu_state_e  state;
    logic        started;
    logic        kill;
    logic [31:0] pc;
    logic [31:0] req_addr;

    logic        out_valid_q;
    logic [31:0] out_inst_q;
    logic [31:0] out_pc_q;
    logic        out_fault_q;

    logic [31:0] redirect_target;
    logic [31:0] pc_seq;
    logic        redirect;
    logic        ar_fire;
    logic        resp_fault;

    assign redirect_target = align_pc(bus.redirect_pc);
    assign pc_seq          = pc + PC_INCR;
    assign redirect        = bus.redirect_valid;
    assign ar_fire         = bus.arvalid & bus.arready;
    assign resp_fault      = (bus.rresp != AXI_RESP_OKAY);

    // 'started' keeps arvalid low throughout reset and for the release cycle.
    assign bus.arvalid   = started & (state == REQ);
    assign bus.araddr    = req_addr;
    assign bus.rready    = (state == WAIT);
    assign bus.out_valid = out_valid_q;
    assign bus.out_inst  = out_inst_q;
    assign bus.out_pc    = out_pc_q;
    assign bus.out_fault = out_fault_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= REQ;
            started     <= 1'b0;
            kill        <= 1'b0;
            pc          <= RESET_PC;
            req_addr    <= RESET_PC;
            out_valid_q <= 1'b0;
            out_inst_q  <= 32'h0;
            out_pc_q    <= 32'h0;
            out_fault_q <= 1'b0;
        end else begin
            started <= 1'b1;
            unique case (state)
                REQ: begin
                    // araddr is frozen once presented; a redirect only marks the beat stale.
                    if (redirect) begin
                        pc <= redirect_target;
                        if (started) begin
                            kill <= 1'b1;
                        end else begin
                            req_addr <= redirect_target;
                        end
                    end
                    if (ar_fire) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.rvalid) begin
                        kill  <= 1'b0;
                        state <= REQ;
                        if (redirect) begin
                            pc       <= redirect_target;
                            req_addr <= redirect_target;
                        end else if (kill) begin
                            req_addr <= pc;
                        end else begin
                            state       <= HOLD;
                            out_valid_q <= 1'b1;
                            out_pc_q    <= pc;
                            out_fault_q <= resp_fault;
                            out_inst_q  <= resp_fault ? NOP_INST : bus.rdata;
                        end
                    end else if (redirect) begin
                        pc   <= redirect_target;
                        kill <= 1'b1;
                    end
                end
                HOLD: begin
                    // Redirect beats a same-cycle decode handshake; decode squashes that one.
                    if (redirect) begin
                        out_valid_q <= 1'b0;
                        pc          <= redirect_target;
                        req_addr    <= redirect_target;
                        state       <= REQ;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        pc          <= pc_seq;
                        req_addr    <= pc_seq;
                        state       <= REQ;
                    end
                end
                default: begin
                    state <= REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24080006_ifu.sv
// tb/tb_ysyx_24080006_ifu.sv - self-checking bench for the instruction fetch unit
module tb_ysyx_24080006_ifu;

    localparam logic [31:0] RST_PC = 32'h3000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clock = ~clock;

    ysyx_24080006_ifu_if bus();

    ysyx_24080006_ifu dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] mem_inst(input logic [31:0] a);
        return a ^ 32'h5a5a_0000 ^ {a[15:0], a[31:16]};
    endfunction

    function automatic bit mem_fault(input logic [31:0] a);
        return (a[5:2] == 4'hb);
    endfunction

    task automatic idle_inputs();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.arready        = 1'b0;
        bus.rvalid         = 1'b0;
        bus.rdata          = 32'h0;
        bus.rresp          = 2'b00;
        bus.out_ready      = 1'b0;
    endtask

    task automatic wait_sig(input int which, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if ((which == 0 && bus.arvalid === 1'b1) ||
                (which == 1 && bus.rready === 1'b1) ||
                (which == 2 && bus.out_valid === 1'b1)) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout_%s got=0 exp=1 within 12 cycles", name);
        end
    endtask

    task automatic fetch_one(input logic [31:0] data, input logic [1:0] resp);
        wait_sig(0, "arvalid");
        bus.arready = 1'b1;
        @(negedge clock);
        bus.arready = 1'b0;
        wait_sig(1, "rready");
        bus.rvalid = 1'b1;
        bus.rdata  = data;
        bus.rresp  = resp;
        @(negedge clock);
        bus.rvalid = 1'b0;
        wait_sig(2, "out_valid");
    endtask

    task automatic handshake_out();
        bus.out_ready = 1'b1;
        @(negedge clock);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_checks++;
            if ({bus.arvalid, bus.rready, bus.out_valid, bus.out_fault} !== 4'b0 ||
                bus.out_inst !== 32'h0 || bus.out_pc !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_outputs got=%b%b%b%b inst=%h pc=%h exp=0000 inst=0 pc=0",
                         bus.arvalid, bus.rready, bus.out_valid, bus.out_fault, bus.out_inst, bus.out_pc);
            end
        end
        rst_n = 1'b1;
        @(negedge clock);
        n_checks++;
        if (bus.arvalid !== 1'b1 || bus.araddr !== RST_PC) begin
            n_fail++;
            $display("FAIL reset_first_req got=%b/%h exp=1/%h", bus.arvalid, bus.araddr, RST_PC);
        end
    endtask

    task automatic test_basic();
        fetch_one(32'h0010_0093, 2'b00);
        n_checks++;
        if (bus.out_inst !== 32'h0010_0093 || bus.out_pc !== RST_PC || bus.out_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_out got=%h/%h/%b exp=00100093/%h/0", bus.out_inst, bus.out_pc, bus.out_fault, RST_PC);
        end
        handshake_out();
        wait_sig(0, "arvalid");
        n_checks++;
        if (bus.araddr !== 32'h3000_0004) begin
            n_fail++;
            $display("FAIL basic_next_araddr got=%h exp=30000004", bus.araddr);
        end
    endtask

    task automatic test_stall();
        logic [31:0] inst0, pc0;
        fetch_one(32'h0020_0113, 2'b00);
        inst0 = bus.out_inst;
        pc0   = bus.out_pc;
        n_checks++;
        if (pc0 !== 32'h3000_0004 || inst0 !== 32'h0020_0113) begin
            n_fail++;
            $display("FAIL stall_first got=%h/%h exp=30000004/00200113", pc0, inst0);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_inst !== inst0 || bus.out_pc !== pc0 ||
                bus.out_fault !== 1'b0 || bus.arvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold got=v%b %h/%h f%b ar%b exp=v1 %h/%h f0 ar0",
                         bus.out_valid, bus.out_inst, bus.out_pc, bus.out_fault, bus.arvalid, inst0, pc0);
            end
        end
        handshake_out();
        wait_sig(0, "arvalid");
        n_checks++;
        if (bus.araddr !== 32'h3000_0008) begin
            n_fail++;
            $display("FAIL stall_next_araddr got=%h exp=30000008", bus.araddr);
        end
    endtask

    task automatic test_redirect_wait();
        wait_sig(0, "arvalid");
        bus.arready = 1'b1;
        @(negedge clock);
        bus.arready        = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0010;
        @(negedge clock);
        bus.redirect_valid = 1'b0;
        @(negedge clock);
        n_checks++;
        if (bus.rready !== 1'b1) begin
            n_fail++;
            $display("FAIL rw_rready got=%b exp=1", bus.rready);
        end
        bus.rvalid = 1'b1;
        bus.rdata  = 32'hdead_beef;
        bus.rresp  = 2'b00;
        @(negedge clock);
        bus.rvalid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.arvalid !== 1'b1 || bus.araddr !== 32'h8000_0010) begin
            n_fail++;
            $display("FAIL rw_drop got=ov%b ar%b/%h exp=ov0 ar1/80000010", bus.out_valid, bus.arvalid, bus.araddr);
        end
        fetch_one(32'h0000_0513, 2'b00);
        n_checks++;
        if (bus.out_pc !== 32'h8000_0010 || bus.out_inst !== 32'h0000_0513) begin
            n_fail++;
            $display("FAIL rw_target got=%h/%h exp=80000010/00000513", bus.out_pc, bus.out_inst);
        end
        handshake_out();
    endtask

    task automatic test_redirect_req();
        wait_sig(0, "arvalid");
        n_checks++;
        if (bus.araddr !== 32'h8000_0014) begin
            n_fail++;
            $display("FAIL rq_start got=%h exp=80000014", bus.araddr);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h4000_0203;
        @(negedge clock);
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h8000_0014) begin
                n_fail++;
                $display("FAIL rq_stable got=%b/%h exp=1/80000014", bus.arvalid, bus.araddr);
            end
            @(negedge clock);
        end
        bus.arready = 1'b1;
        @(negedge clock);
        bus.arready = 1'b0;
        wait_sig(1, "rready");
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h1234_5678;
        @(negedge clock);
        bus.rvalid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.arvalid !== 1'b1 || bus.araddr !== 32'h4000_0200) begin
            n_fail++;
            $display("FAIL rq_drop got=ov%b ar%b/%h exp=ov0 ar1/40000200", bus.out_valid, bus.arvalid, bus.araddr);
        end
        fetch_one(32'h0000_0593, 2'b00);
        n_checks++;
        if (bus.out_pc !== 32'h4000_0200 || bus.out_inst !== 32'h0000_0593) begin
            n_fail++;
            $display("FAIL rq_target got=%h/%h exp=40000200/00000593", bus.out_pc, bus.out_inst);
        end
        handshake_out();
    endtask

    task automatic test_fault();
        fetch_one(32'hffff_ffff, 2'b10);
        n_checks++;
        if (bus.out_fault !== 1'b1 || bus.out_inst !== NOP || bus.out_pc !== 32'h4000_0204) begin
            n_fail++;
            $display("FAIL fault_out got=f%b %h/%h exp=f1 %h/40000204", bus.out_fault, bus.out_inst, bus.out_pc, NOP);
        end
        handshake_out();
        wait_sig(0, "arvalid");
        n_checks++;
        if (bus.araddr !== 32'h4000_0208) begin
            n_fail++;
            $display("FAIL fault_next got=%h exp=40000208", bus.araddr);
        end
    endtask

    task automatic test_wrap();
        fetch_one(32'h0000_0613, 2'b00);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hffff_fffc;
        bus.out_ready      = 1'b1;
        @(negedge clock);
        bus.redirect_valid = 1'b0;
        bus.out_ready      = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.arvalid !== 1'b1 || bus.araddr !== 32'hffff_fffc) begin
            n_fail++;
            $display("FAIL wrap_redirect_hold got=ov%b ar%b/%h exp=ov0 ar1/fffffffc", bus.out_valid, bus.arvalid, bus.araddr);
        end
        fetch_one(32'h0000_0073, 2'b00);
        n_checks++;
        if (bus.out_pc !== 32'hffff_fffc || bus.out_inst !== 32'h0000_0073) begin
            n_fail++;
            $display("FAIL wrap_out got=%h/%h exp=fffffffc/00000073", bus.out_pc, bus.out_inst);
        end
        handshake_out();
        wait_sig(0, "arvalid");
        n_checks++;
        if (bus.araddr !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL wrap_next got=%h exp=00000000", bus.araddr);
        end
    endtask

    task automatic test_async_reset();
        wait_sig(0, "arvalid");
        bus.arready = 1'b1;
        @(negedge clock);
        bus.arready = 1'b0;
        n_checks++;
        if (bus.rready !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_in_wait got=%b exp=1", bus.rready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.arvalid, bus.rready, bus.out_valid, bus.out_fault} !== 4'b0 ||
            bus.out_inst !== 32'h0 || bus.out_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL areset_async got=%b%b%b%b inst=%h pc=%h exp=0000 inst=0 pc=0",
                     bus.arvalid, bus.rready, bus.out_valid, bus.out_fault, bus.out_inst, bus.out_pc);
        end
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        n_checks++;
        if (bus.arvalid !== 1'b1 || bus.araddr !== RST_PC) begin
            n_fail++;
            $display("FAIL areset_restart got=%b/%h exp=1/%h", bus.arvalid, bus.araddr, RST_PC);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc = RST_PC;
        logic [31:0] pend_addr = 32'h0;
        bit          pend = 1'b0;
        int          pend_dly = 0;
        int          delivered = 0;
        logic        p_arv = 1'b0, p_ardy = 1'b0, p_ov = 1'b0, p_ordy = 1'b0, p_redir = 1'b0, p_of = 1'b0;
        logic [31:0] p_ara = 32'h0, p_op = 32'h0, p_oi = 32'h0;
        logic        arv, rr, ov, of, redir;
        logic [31:0] ara, op, oi, tgt, exp_i;
        bit          exp_f;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clock);
            arv = bus.arvalid; ara = bus.araddr; rr = bus.rready;
            ov = bus.out_valid; op = bus.out_pc; oi = bus.out_inst; of = bus.out_fault;
            if (p_arv && !p_ardy) begin
                n_checks++;
                if (arv !== 1'b1 || ara !== p_ara) begin
                    n_fail++;
                    $display("FAIL rnd_ar_stable cyc=%0d got=%b/%h exp=1/%h", cyc, arv, ara, p_ara);
                end
            end
            if (p_ov && !p_ordy && !p_redir) begin
                n_checks++;
                if (ov !== 1'b1 || op !== p_op || oi !== p_oi || of !== p_of) begin
                    n_fail++;
                    $display("FAIL rnd_out_stable cyc=%0d got=%b %h/%h/%b exp=1 %h/%h/%b", cyc, ov, op, oi, of, p_op, p_oi, p_of);
                end
            end
            if (pend && pend_dly > 0) pend_dly--;
            bus.rvalid = pend && (pend_dly == 0);
            bus.rdata  = bus.rvalid ? mem_inst(pend_addr) : $urandom;
            bus.rresp  = (bus.rvalid && mem_fault(pend_addr)) ? 2'($urandom_range(1, 3)) : 2'b00;
            if (bus.rvalid && rr) pend = 1'b0;
            bus.arready = ($urandom_range(0, 2) != 0);
            if (arv && bus.arready) begin
                n_checks++;
                if (pend) begin
                    n_fail++;
                    $display("FAIL rnd_outstanding cyc=%0d got=2 reads exp=1", cyc);
                end
                pend      = 1'b1;
                pend_addr = ara;
                pend_dly  = $urandom_range(1, 3);
            end
            bus.out_ready = 1'($urandom_range(0, 1));
            redir = ($urandom_range(0, 14) == 0);
            tgt   = $urandom;
            bus.redirect_valid = redir;
            bus.redirect_pc    = tgt;
            if (ov && bus.out_ready && !redir) begin
                exp_f = mem_fault(exp_pc);
                exp_i = exp_f ? NOP : mem_inst(exp_pc);
                n_checks++;
                if (op !== exp_pc || oi !== exp_i || of !== exp_f) begin
                    n_fail++;
                    $display("FAIL rnd_deliver cyc=%0d got=%h/%h/%b exp=%h/%h/%b", cyc, op, oi, of, exp_pc, exp_i, exp_f);
                end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (redir) exp_pc = {tgt[31:2], 2'b00};
            p_arv = arv; p_ara = ara; p_ardy = bus.arready;
            p_ov = ov; p_op = op; p_oi = oi; p_of = of; p_ordy = bus.out_ready; p_redir = redir;
        end
        @(negedge clock);
        idle_inputs();
        n_checks++;
        if (delivered < 100) begin
            n_fail++;
            $display("FAIL rnd_progress got=%0d exp>=100", delivered);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_redirect_req();
        test_fault();
        test_wrap();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
